onchip_mem_arbiter: RTL and testbench

- Two-requester Avalon-MM arbiter that shares the single-port 49152x32 on-chip RAM (q_sys onchip memory, 2-cycle read latency) between two masters, e.g. the CPU data path and the TPU/ECC datapath DMA.
- Grants at most one access per cycle, round-robin.
- Tracks in-flight reads so each returned word goes to the requester that issued it.
- Drops out-of-range accesses safely.

---
 rtl/onchip_mem_arb_pkg.sv | 20 ++
 rtl/onchip_mem_rd_tag_pipe.sv | 34 +++
 rtl/onchip_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and constants for the two-requester on-chip RAM arbiter.
//   ARB_NREQ     : number of requesters sharing the RAM port
//   RAM_NUMWORDS : number of valid RAM words; higher addresses are out of range
//   RAM_RD_LAT   : cycles from accepted read to readdata valid
//   rd_tag_t     : per-read bookkeeping carried alongside the RAM read pipeline
package onchip_mem_arb_pkg;

   localparam int unsigned ARB_NREQ     = 2;
   localparam int unsigned RAM_NUMWORDS = 49152;
   localparam int unsigned RAM_RD_LAT   = 2;

   typedef struct packed {
      logic valid;  // a read was accepted in this slot
      logic id;     // requester that issued it
      logic oor;    // address was out of range, return zero
   } rd_tag_t;

   localparam int unsigned RD_TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/onchip_mem_rd_tag_pipe.sv
// DEPTH-stage shift register of read tags that tracks in-flight RAM reads.
//   clk   : system clock
//   i_clr : synchronous clear, drops every in-flight tag
//   i_tag : tag entering the pipe (packed rd_tag_t)
//   o_tag : tag leaving the pipe, aligned with RAM readdata
module onchip_mem_rd_tag_pipe
   import onchip_mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = RAM_RD_LAT
) (
   input  logic                clk,
   input  logic                i_clr,
   input  logic [RD_TAG_W-1:0] i_tag,
   output logic [RD_TAG_W-1:0] o_tag
);

   rd_tag_t r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= rd_tag_t'(i_tag);
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM
// requesters. At most one access is granted per cycle; reads are fully pipelined
// and each returned word is steered back to the requester that issued it.
// Out-of-range accesses are accepted without touching the RAM and flagged.
//   clk, reset        : clock, synchronous active-high reset
//   s0_* / s1_*       : requester slave ports (address, byteenable, read, write,
//                       writedata, waitrequest, readdata, readdatavalid, oor_err)
//   mem_*             : RAM master port (address, byteenable, chipselect, write,
//                       writedata, clken, readdata)
module onchip_mem_arbiter
   import onchip_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned BE_W     = DATA_W / 8,
   parameter int unsigned NUMWORDS = RAM_NUMWORDS,
   parameter int unsigned RD_LAT   = RAM_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   // requester 0
   input  logic [ADDR_W-1:0] s0_address,
   input  logic [BE_W-1:0]   s0_byteenable,
   input  logic              s0_read,
   input  logic              s0_write,
   input  logic [DATA_W-1:0] s0_writedata,
   output logic              s0_waitrequest,
   output logic [DATA_W-1:0] s0_readdata,
   output logic              s0_readdatavalid,
   output logic              s0_oor_err,
   // requester 1
   input  logic [ADDR_W-1:0] s1_address,
   input  logic [BE_W-1:0]   s1_byteenable,
   input  logic              s1_read,
   input  logic              s1_write,
   input  logic [DATA_W-1:0] s1_writedata,
   output logic              s1_waitrequest,
   output logic [DATA_W-1:0] s1_readdata,
   output logic              s1_readdatavalid,
   output logic              s1_oor_err,
   // RAM
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic    w_req0, w_req1;
   logic    w_gnt0, w_gnt1;
   logic    w_oor0, w_oor1;
   logic    w_sel, w_acc, w_oor_sel, w_wr_sel;
   rd_tag_t w_tag_in, w_tag_out;
   logic    w_rdv0, w_rdv1;
   logic [DATA_W-1:0] w_rdata;

   logic    r_ptr;  // requester favoured on contention
   logic    r_oor_err0, r_oor_err1;
   logic [DATA_W-1:0] r_rdata0, r_rdata1;

   // ---------------------------------------------------------------- arbitration
   assign w_req0 = s0_read | s0_write;
   assign w_req1 = s1_read | s1_write;

   // Nothing is granted during reset, so nothing issued then reaches the RAM.
   assign w_gnt0 = ~reset & w_req0 & (~w_req1 | ~r_ptr);
   assign w_gnt1 = ~reset & w_req1 & (~w_req0 |  r_ptr);

   assign s0_waitrequest = reset | (w_req0 & ~w_gnt0);
   assign s1_waitrequest = reset | (w_req1 & ~w_gnt1);

   // Zero-extend so a NUMWORDS equal to 2**ADDR_W still compares correctly.
   assign w_oor0 = (64'(s0_address) >= 64'(NUMWORDS));
   assign w_oor1 = (64'(s1_address) >= 64'(NUMWORDS));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= 1'b0;
      end else if (w_req0 && w_req1) begin
         r_ptr <= ~w_sel;  // hand priority to the loser
      end
   end

   // ------------------------------------------------------------------ RAM side
   assign w_sel     = w_gnt1;
   assign w_acc     = w_gnt0 | w_gnt1;
   assign w_oor_sel = w_sel ? w_oor1 : w_oor0;
   // read+write together is illegal and resolves as a write
   assign w_wr_sel  = w_sel ? s1_write : s0_write;

   assign mem_address    = w_sel ? s1_address    : s0_address;
   assign mem_byteenable = w_sel ? s1_byteenable : s0_byteenable;
   assign mem_writedata  = w_sel ? s1_writedata  : s0_writedata;
   assign mem_chipselect = w_acc & ~w_oor_sel;
   assign mem_write      = w_acc & ~w_oor_sel & w_wr_sel;
   assign mem_clken      = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_oor_err0 <= 1'b0;
         r_oor_err1 <= 1'b0;
      end else begin
         r_oor_err0 <= w_gnt0 & w_oor0;
         r_oor_err1 <= w_gnt1 & w_oor1;
      end
   end

   assign s0_oor_err = r_oor_err0 & ~reset;
   assign s1_oor_err = r_oor_err1 & ~reset;

   // ------------------------------------------------------------- read returns
   always_comb begin
      w_tag_in       = '0;
      w_tag_in.valid = w_acc & ~w_wr_sel;
      w_tag_in.id    = w_sel;
      w_tag_in.oor   = w_oor_sel;
   end

   onchip_mem_rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_tag_pipe (
      .clk   (clk),
      .i_clr (reset),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );

   assign w_rdv0  = ~reset & w_tag_out.valid & ~w_tag_out.id;
   assign w_rdv1  = ~reset & w_tag_out.valid &  w_tag_out.id;
   assign w_rdata = w_tag_out.oor ? '0 : mem_readdata;

   // Returned word is forwarded combinationally to meet latency; the hold
   // registers keep it on the port until that requester's next return.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (w_rdv0) r_rdata0 <= w_rdata;
         if (w_rdv1) r_rdata1 <= w_rdata;
      end
   end

   assign s0_readdatavalid = w_rdv0;
   assign s1_readdatavalid = w_rdv1;
   assign s0_readdata      = reset ? '0 : (w_rdv0 ? w_rdata : r_rdata0);
   assign s1_readdata      = reset ? '0 : (w_rdv1 ? w_rdata : r_rdata1);

`ifndef SYNTHESIS
   a_s0_rw_excl : assert property (@(posedge clk) disable iff (reset) !(s0_read && s0_write));
   a_s1_rw_excl : assert property (@(posedge clk) disable iff (reset) !(s1_read && s1_write));
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomised self-checking bench for onchip_mem_arbiter with a behavioural
// 2-cycle RAM and a cycle-level reference model of arbitration and returns.
module tb_onchip_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int NW = 49152;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0][AW-1:0] addr;
   logic [1:0][BW-1:0] be;
   logic [1:0]         rd, wr;
   logic [1:0][DW-1:0] wdata;
   wire  [1:0]         wreq, rdv, oor;
   wire  [1:0][DW-1:0] rdata;

   wire  [AW-1:0] mem_address;
   wire  [BW-1:0] mem_byteenable;
   wire           mem_chipselect, mem_write, mem_clken;
   wire  [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_readdata;

   onchip_mem_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .s0_address       (addr[0]),
      .s0_byteenable    (be[0]),
      .s0_read          (rd[0]),
      .s0_write         (wr[0]),
      .s0_writedata     (wdata[0]),
      .s0_waitrequest   (wreq[0]),
      .s0_readdata      (rdata[0]),
      .s0_readdatavalid (rdv[0]),
      .s0_oor_err       (oor[0]),
      .s1_address       (addr[1]),
      .s1_byteenable    (be[1]),
      .s1_read          (rd[1]),
      .s1_write         (wr[1]),
      .s1_writedata     (wdata[1]),
      .s1_waitrequest   (wreq[1]),
      .s1_readdata      (rdata[1]),
      .s1_readdatavalid (rdv[1]),
      .s1_oor_err       (oor[1]),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   // RAM: read data captured at the access edge, so later writes cannot alter it.
   logic [DW-1:0] ram [NW];
   logic [DW-1:0] ram_s1, ram_s2;
   always @(posedge clk) begin
      if (mem_chipselect && mem_write) begin
         for (int b = 0; b < BW; b++) begin
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end
      end
      ram_s1 <= (int'(mem_address) < NW) ? ram[mem_address] : 32'hBAD0BAD0;
      ram_s2 <= ram_s1;
   end
   assign mem_readdata = ram_s2;

   // ------------------------------------------------------------ reference model
   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } pend_t;

   logic [DW-1:0] shadow [NW];
   pend_t         pend [$];
   int            m_ptr;
   logic [DW-1:0] m_last [2];
   bit            m_oor_next [2];
   bit            m_stall [2];
   int            cyc;
   int            n_cmp, n_bad;
   int            cnt_rdv1, cnt_wait1, cnt_oor0, cnt_rdv_any;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Checks the current cycle against the model, then advances one clock.
   task automatic step();
      bit    req [2];
      bit    gnt [2];
      bit    exp_rdv [2];
      bit    any, isoor;
      int    win, a;
      pend_t e;
      @(negedge clk);
      for (int p = 0; p < 2; p++) req[p] = rd[p] | wr[p];
      cnt_rdv1    += int'(rdv[1]);
      cnt_wait1   += int'(wreq[1]);
      cnt_oor0    += int'(oor[0]);
      cnt_rdv_any += int'(rdv[0]) + int'(rdv[1]);
      check_eq("clken", 32'(mem_clken), 32'd1);
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("rst_wait%0d", p), 32'(wreq[p]), 32'd1);
            check_eq($sformatf("rst_rdv%0d", p), 32'(rdv[p]), 32'd0);
            check_eq($sformatf("rst_rdata%0d", p), rdata[p], 32'd0);
            check_eq($sformatf("rst_oor%0d", p), 32'(oor[p]), 32'd0);
            m_last[p] = '0;
            m_oor_next[p] = 1'b0;
            m_stall[p] = 1'b0;
         end
         check_eq("rst_cs", 32'(mem_chipselect), 32'd0);
         check_eq("rst_mwr", 32'(mem_write), 32'd0);
         pend.delete();
         m_ptr = 0;
      end else begin
         any = req[0] | req[1];
         win = (req[0] && req[1]) ? m_ptr : (req[1] ? 1 : 0);
         for (int p = 0; p < 2; p++) begin
            gnt[p] = any && (win == p);
            exp_rdv[p] = 1'b0;
            check_eq($sformatf("wait%0d", p), 32'(wreq[p]), 32'(req[p] && !gnt[p]));
            check_eq($sformatf("oor%0d", p), 32'(oor[p]), 32'(m_oor_next[p]));
            m_oor_next[p] = 1'b0;
         end
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            exp_rdv[e.id] = 1'b1;
            m_last[e.id] = e.data;
         end
         for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("rdv%0d", p), 32'(rdv[p]), 32'(exp_rdv[p]));
            check_eq($sformatf("rdata%0d", p), rdata[p], m_last[p]);
         end
         if (any) begin
            a = int'(addr[win]);
            isoor = (a >= NW);
            check_eq("cs", 32'(mem_chipselect), 32'(!isoor));
            check_eq("mwr", 32'(mem_write), 32'(!isoor && wr[win]));
            if (!isoor) begin
               check_eq("maddr", 32'(mem_address), 32'(a));
               check_eq("mbe", 32'(mem_byteenable), 32'(be[win]));
            end
            if (wr[win]) begin
               if (!isoor) begin
                  check_eq("mwdata", mem_writedata, wdata[win]);
                  for (int b = 0; b < BW; b++) begin
                     if (be[win][b]) shadow[a][8*b +: 8] = wdata[win][8*b +: 8];
                  end
               end
            end else begin
               e.due = cyc + LAT;
               e.id = win;
               e.data = isoor ? '0 : shadow[a];
               pend.push_back(e);
            end
            m_oor_next[win] = isoor;
         end else begin
            check_eq("cs_idle", 32'(mem_chipselect), 32'd0);
         end
         if (req[0] && req[1]) m_ptr = 1 - win;
         for (int p = 0; p < 2; p++) m_stall[p] = req[p] && !gnt[p];
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_port(input int p, input bit r, input bit w, input int a,
                           input logic [BW-1:0] b, input logic [DW-1:0] d);
      rd[p] = r;
      wr[p] = w;
      addr[p] = AW'(a);
      be[p] = b;
      wdata[p] = d;
   endtask

   task automatic idle(input int n);
      set_port(0, 0, 0, 0, '0, '0);
      set_port(1, 0, 0, 0, '0, '0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rand_port(input int p);
      int op, sel, a;
      op = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 9));
      case (sel)
         0:       a = 16'hBFFF;
         1:       a = int'($urandom_range(16'hC000, 16'hFFFF));
         2:       a = 16'hFFFF;
         default: a = int'($urandom_range(0, 255));
      endcase
      set_port(p, op >= 3 && op < 7, op >= 7, a, BW'($urandom), $urandom);
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin
         ram[i] = $urandom;
      end
      ram[16'h0010] = 32'hDEADBEEF;
      ram[16'h0100] = 32'hAAAAAAAA;
      for (int i = 0; i < NW; i++) shadow[i] = ram[i];
      n_cmp = 0;
      n_bad = 0;
      cyc = 0;
      m_ptr = 0;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(2);

      // single read
      set_port(0, 1, 0, 16'h0010, 4'hF, '0);
      step();
      idle(3);
      check_eq("single_read", rdata[0], 32'hDEADBEEF);

      // contention from pointer 0: grants alternate s0,s1,s0,s1
      for (int i = 0; i < 4; i++) begin
         set_port(0, 1, 0, 16'h0020 + i, 4'hF, '0);
         set_port(1, 1, 0, 16'h0030 + i, 4'hF, '0);
         step();
      end
      idle(3);

      // byte-masked write then read back
      set_port(1, 0, 1, 16'h0100, 4'h3, 32'h12345678);
      step();
      set_port(1, 0, 0, 0, '0, '0);
      set_port(0, 1, 0, 16'h0100, 4'hF, '0);
      step();
      idle(3);
      check_eq("wr_then_rd", rdata[0], 32'hAAAA5678);

      // range boundary
      cnt_oor0 = 0;
      set_port(0, 0, 1, 16'hBFFF, 4'hF, 32'h0BADCAFE);
      step();
      set_port(0, 0, 1, 16'hC000, 4'hF, 32'h11111111);
      step();
      idle(2);
      check_eq("oor_pulses", 32'(cnt_oor0), 32'd1);
      set_port(0, 1, 0, 16'hFFFF, 4'hF, '0);
      step();
      idle(3);
      check_eq("oor_read", rdata[0], 32'd0);

      // reset with two reads in flight
      cnt_rdv_any = 0;
      set_port(0, 1, 0, 16'h0010, 4'hF, '0);
      step();
      set_port(0, 1, 0, 16'h0011, 4'hF, '0);
      step();
      set_port(0, 0, 0, 0, '0, '0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle(4);
      check_eq("rst_flush", 32'(cnt_rdv_any), 32'd0);
      set_port(0, 1, 0, 16'h0040, 4'hF, '0);
      set_port(1, 1, 0, 16'h0041, 4'hF, '0);
      step();
      idle(3);

      // streaming from s1 alone
      cnt_rdv1 = 0;
      cnt_wait1 = 0;
      for (int i = 0; i < 100; i++) begin
         set_port(1, 1, 0, 16'h0200 + i, 4'hF, '0);
         step();
      end
      idle(3);
      check_eq("stream_rdv", 32'(cnt_rdv1), 32'd100);
      check_eq("stream_wait", 32'(cnt_wait1), 32'd0);

      // random traffic, stalled requests held stable
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         for (int p = 0; p < 2; p++) begin
            if (!m_stall[p]) rand_port(p);
         end
         step();
      end
      reset = 1'b0;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
